// File: rtl/nios_setup_led_pwm.sv
// nios_setup_led_pwm: Avalon-MM LED output controller for the Nios II system.
// Each of WIDTH channels drives either a directly written level or a PWM
// brightness, optionally gated by a shared blink phase.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   address    word address of the slave register
//   chipselect slave select
//   write_n    active-low write strobe (write = chipselect && !write_n)
//   writedata  write data, unused upper bits ignored
//   readdata   combinational read data, zero-wait-state
//   out_port   registered LED outputs
module nios_setup_led_pwm #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam int unsigned CNT_W = 16;

    localparam logic [3:0] ADDR_DATA       = 4'd0;
    localparam logic [3:0] ADDR_MODE       = 4'd1;
    localparam logic [3:0] ADDR_OUTSET     = 4'd2;
    localparam logic [3:0] ADDR_OUTCLEAR   = 4'd3;
    localparam logic [3:0] ADDR_PRESCALE   = 4'd4;
    localparam logic [3:0] ADDR_BLINK      = 4'd5;
    localparam logic [3:0] ADDR_BLINK_HALF = 4'd6;
    localparam int unsigned ADDR_DUTY_BASE = 8;

    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

    logic                wr_en;
    logic [WIDTH-1:0]    wr_bits;

    logic [WIDTH-1:0]    data_reg;
    logic [WIDTH-1:0]    mode_reg;
    logic [WIDTH-1:0]    blink_reg;
    logic [CNT_W-1:0]    prescale_reg;
    logic [CNT_W-1:0]    blink_half_reg;
    logic [PWM_BITS-1:0] duty_reg [WIDTH];
    logic [PWM_BITS-1:0] duty_act [WIDTH];

    logic [CNT_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [CNT_W-1:0]    blk_cnt;
    logic                phase;

    logic                tick;
    logic                period_end;
    logic [WIDTH-1:0]    pwm_on;
    logic [WIDTH-1:0]    out_nxt;

    // Upper write-data bits carry nothing for this slave.
    logic                unused_wdata;
    assign unused_wdata = &{1'b0, writedata[31:CNT_W]};

    assign wr_en   = chipselect & ~write_n;
    assign wr_bits = writedata[WIDTH-1:0];

    // Control registers; OUTSET/OUTCLEAR modify DATA atomically.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg       <= '0;
            mode_reg       <= '0;
            blink_reg      <= '0;
            prescale_reg   <= '0;
            blink_half_reg <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:       data_reg       <= wr_bits;
                ADDR_MODE:       mode_reg       <= wr_bits;
                ADDR_OUTSET:     data_reg       <= data_reg | wr_bits;
                ADDR_OUTCLEAR:   data_reg       <= data_reg & ~wr_bits;
                ADDR_PRESCALE:   prescale_reg   <= writedata[CNT_W-1:0];
                ADDR_BLINK:      blink_reg      <= wr_bits;
                ADDR_BLINK_HALF: blink_half_reg <= writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Duty registers, one word per channel starting at the duty base address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                duty_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (wr_en && (address == 4'(int'(ADDR_DUTY_BASE) + i))) begin
                    duty_reg[i] <= writedata[PWM_BITS-1:0];
                end
            end
        end
    end

    // Prescaler: tick on reaching PRESCALE; a PRESCALE write restarts it.
    assign tick       = (pre_cnt == prescale_reg);
    assign period_end = tick & (&pwm_cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (wr_en && (address == ADDR_PRESCALE)) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + CNT_ONE;
        end
    end

    // PWM counter; duty is shadowed at period boundaries so each period is glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                duty_act[i] <= '0;
            end
        end else begin
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_ONE;
            end
            if (period_end) begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    duty_act[i] <= duty_reg[i];
                end
            end
        end
    end

    // Blink timer counts PWM periods; a BLINK_HALF below blk_cnt is only
    // matched again after blk_cnt wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt <= '0;
            phase   <= 1'b1;
        end else if (period_end) begin
            if (blk_cnt == blink_half_reg) begin
                blk_cnt <= '0;
                phase   <= ~phase;
            end else begin
                blk_cnt <= blk_cnt + CNT_ONE;
            end
        end
    end

    // Per-channel PWM compare and output selection.
    always_comb begin
        pwm_on  = '0;
        out_nxt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pwm_on[i]  = (pwm_cnt < duty_act[i]);
            out_nxt[i] = (mode_reg[i] ? pwm_on[i] : data_reg[i]) & (~blink_reg[i] | phase);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= '0;
        end else begin
            out_port <= out_nxt;
        end
    end

    // Read mux; write-only and unmapped addresses return 0.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:       readdata = 32'(data_reg);
            ADDR_MODE:       readdata = 32'(mode_reg);
            ADDR_PRESCALE:   readdata = 32'(prescale_reg);
            ADDR_BLINK:      readdata = 32'(blink_reg);
            ADDR_BLINK_HALF: readdata = 32'(blink_half_reg);
            default: ;
        endcase
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (address == 4'(int'(ADDR_DUTY_BASE) + i)) begin
                readdata = 32'(duty_reg[i]);
            end
        end
    end

endmodule

// File: tb/tb_nios_setup_led_pwm.sv
// Bench for nios_setup_led_pwm: directed scenarios plus randomized bus
// traffic, with every readdata and out_port value compared against a
// cycle-level integer reference model of the register map and timers.
`timescale 1ns/1ps
module tb_nios_setup_led_pwm;

    localparam int unsigned WIDTH    = 5;
    localparam int unsigned PWM_BITS = 8;
    localparam int P     = 1 << PWM_BITS;
    localparam int WMASK = (1 << WIDTH) - 1;
    localparam int DMASK = P - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [3:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [WIDTH-1:0]  out_port;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nios_setup_led_pwm #(.WIDTH(WIDTH), .PWM_BITS(PWM_BITS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    // Reference model state (plain integers)
    int m_data, m_mode, m_blink, m_pre, m_bhalf;
    int m_duty [WIDTH];
    int m_dact [WIDTH];
    int m_precnt, m_pwm, m_blk, m_phase, m_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data = 0; m_mode = 0; m_blink = 0; m_pre = 0; m_bhalf = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            m_duty[i] = 0;
            m_dact[i] = 0;
        end
        m_precnt = 0; m_pwm = 0; m_blk = 0; m_phase = 1; m_out = 0;
    endtask

    function automatic int model_read(input int a);
        case (a)
            0: return m_data;
            1: return m_mode;
            4: return m_pre;
            5: return m_blink;
            6: return m_bhalf;
            default: begin
                if (a >= 8 && a < 8 + int'(WIDTH)) return m_duty[a - 8];
                return 0;
            end
        endcase
    endfunction

    // One clock edge of the model; outputs use pre-edge values, writes land after.
    task automatic model_step(input bit wr, input int a, input int wd);
        bit tick, pend;
        int nxt, lvl;
        tick = (m_precnt == m_pre);
        pend = tick && (m_pwm == P - 1);
        nxt = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if ((m_mode >> i) & 1) lvl = (m_pwm < m_dact[i]) ? 1 : 0;
            else                   lvl = (m_data >> i) & 1;
            if (((m_blink >> i) & 1) && m_phase == 0) lvl = 0;
            nxt |= lvl << i;
        end
        m_out = nxt;
        if (wr && a == 4)  m_precnt = 0;
        else if (tick)     m_precnt = 0;
        else               m_precnt = m_precnt + 1;
        if (tick) m_pwm = (m_pwm + 1) % P;
        if (pend) begin
            for (int i = 0; i < int'(WIDTH); i++) m_dact[i] = m_duty[i];
            if (m_blk == m_bhalf) begin
                m_blk = 0;
                m_phase = 1 - m_phase;
            end else begin
                m_blk = (m_blk + 1) % 65536;
            end
        end
        if (wr) begin
            case (a)
                0: m_data  = wd & WMASK;
                1: m_mode  = wd & WMASK;
                2: m_data  = m_data | (wd & WMASK);
                3: m_data  = m_data & ~(wd & WMASK);
                4: m_pre   = wd & 'hFFFF;
                5: m_blink = wd & WMASK;
                6: m_bhalf = wd & 'hFFFF;
                default: if (a >= 8 && a < 8 + int'(WIDTH)) m_duty[a - 8] = wd & DMASK;
            endcase
        end
    endtask

    // One bus cycle, entered and left at a falling edge.
    task automatic cycle(input bit cs, input bit wr, input int a, input int wd);
        chipselect = cs;
        write_n    = !(cs && wr);
        address    = 4'(a);
        writedata  = 32'(wd);
        #1;
        if (cs) check("readdata", readdata, 32'(model_read(a)));
        @(posedge clk);
        model_step(cs && wr, a, wd);
        @(negedge clk);
        check("out_port", 32'(out_port), 32'(m_out));
    endtask

    task automatic wr(input int a, input int d);
        cycle(1'b1, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 0, 0);
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            idle(1);
            if (out_port[0] === 1'b1) hi++;
        end
    endtask

    // Asynchronous reset between edges; everything must clear immediately.
    task automatic apply_reset();
        chipselect = 1'b1; write_n = 1'b1; address = '0; writedata = '0;
        #2 reset_n = 1'b0;
        #1 check("rst_out_async", 32'(out_port), 32'd0);
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #1 check("rst_read", readdata, 32'd0);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        chipselect = 1'b0;
    endtask

    initial begin
        int hi, n, prev, r, a, d;
        bit found;
        chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("por_out", 32'(out_port), 32'd0);
        reset_n = 1'b1;

        // All addresses read 0 after reset
        for (int k = 0; k < 16; k++) cycle(1'b1, 1'b0, k, 0);

        // Direct levels with atomic set/clear
        wr(0, 'h15);
        wr(2, 'h02);
        wr(3, 'h04);
        cycle(1'b1, 1'b0, 0, 0);
        check("data_setclr_read", readdata, 32'h13);
        check("data_setclr_out", 32'(out_port), 32'h13);

        // PWM brightness on channel 0
        wr(0, 0);
        wr(4, 0);
        wr(8, 64);
        wr(1, 1);
        idle(300);
        count_high(256, hi);
        check("pwm_duty64", 32'(hi), 32'd64);
        wr(8, 0);
        idle(300);
        count_high(256, hi);
        check("pwm_duty0", 32'(hi), 32'd0);
        wr(8, 255);
        idle(300);
        count_high(256, hi);
        check("pwm_duty255", 32'(hi), 32'd255);

        // Duty write mid-period waits for the next boundary
        wr(8, 64);
        idle(300);
        n = 0;
        while (m_pwm != 30 && n < 400) begin
            idle(1);
            n++;
        end
        check("align_slot30", 32'(m_pwm), 32'd30);
        wr(8, 200);
        hi = (out_port[0] === 1'b1) ? 1 : 0;
        count_high(199, n);
        check("shadow_cur_period", 32'(hi + n), 32'd34);
        count_high(256, hi);
        check("shadow_next_period", 32'(hi), 32'd200);

        // Blink: two PWM periods per half with PRESCALE=0
        apply_reset();
        wr(4, 0);
        wr(6, 1);
        wr(0, 1);
        wr(5, 1);
        found = 1'b0;
        prev = (out_port[0] === 1'b1) ? 1 : 0;
        for (int k = 0; k < 1200 && !found; k++) begin
            idle(1);
            if (prev == 0 && out_port[0] === 1'b1) found = 1'b1;
            prev = (out_port[0] === 1'b1) ? 1 : 0;
        end
        check("blink_rise_seen", 32'(found), 32'd1);
        n = 0;
        do begin idle(1); n++; end while (out_port[0] === 1'b1 && n < 2000);
        check("blink_high_run", 32'(n), 32'd512);
        n = 0;
        do begin idle(1); n++; end while (out_port[0] === 1'b0 && n < 2000);
        check("blink_low_run", 32'(n), 32'd512);

        // Reset during blink-off with PWM active
        wr(8, 200);
        wr(1, 1);
        n = 0;
        while (m_phase != 0 && n < 1500) begin
            idle(1);
            n++;
        end
        check("blink_off_reached", 32'(m_phase), 32'd0);
        idle(100);
        apply_reset();

        // Reset while outputs are high
        wr(0, 'h1F);
        idle(2);
        check("pre_reset_high", 32'(out_port), 32'h1F);
        apply_reset();

        // Randomized bus traffic against the model
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom % 4);
            a = int'($urandom % 16);
            case (a)
                4:       d = int'($urandom % 4);
                6:       d = int'($urandom % 3);
                default: d = int'($urandom);
            endcase
            case (r)
                0:       idle(1);
                1:       cycle(1'b1, 1'b0, a, 0);
                default: wr(a, d);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
